// File: rtl/shift_register_ctrl_if.sv
// Controller <-> environment bundle for the universal shift register sequencer.
// The master side issues commands and feeds back register contents; the slave
// side is the controller, which drives the register's mode and serial/parallel inputs.
interface shift_register_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic [WIDTH-1:0] A_par;
  logic             S1;
  logic             S0;
  logic             MSB_in;
  logic             LSB_in;
  logic [WIDTH-1:0] I_par;
  logic             busy;
  logic             done;

  modport master (
    output start, op, count, data_in, serial_in, A_par,
    input  S1, S0, MSB_in, LSB_in, I_par, busy, done
  );

  modport slave (
    input  start, op, count, data_in, serial_in, A_par,
    output S1, S0, MSB_in, LSB_in, I_par, busy, done
  );
endinterface

// File: rtl/shift_register_ctrl.sv
// Sequencer for a universal shift register: runs one load, shift-right,
// shift-left or rotate-right command at a time and pulses done at the end.
//
// state | meaning
// IDLE  | waiting for start, register held
// LOAD  | one cycle of parallel load from the latched word
// SHIFT | count cycles of shifting/rotating, down-counter running
// DONE  | one-cycle completion pulse; a new start is accepted here too
module shift_register_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic                  CLK,
  input logic                  Clear,
  shift_register_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic [1:0]       op_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             unused_a_par;

  // Only the LSB of the fed-back register contents matters (rotate right).
  assign unused_a_par = ^bus.A_par[WIDTH-1:1];

  // A command is taken only when no command is running (IDLE or the DONE cycle).
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // Next state, plus the op that will govern the next cycle's mode select.
  always_comb begin
    state_nx = state;
    op_nx    = accept ? bus.op : op_q;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (accept) begin
          if (bus.op == 2'b00)
            state_nx = LOAD;
          else if (bus.count != '0)
            state_nx = SHIFT;
          else
            state_nx = DONE;
        end
      end
      LOAD:    state_nx = DONE;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) state <= IDLE;
    else       state <= state_nx;
  end

  // Command latch and step down-counter; the latched word doubles as I_par.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      op_q   <= 2'b00;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      cnt_q  <= bus.count;
      data_q <= bus.data_in;
    end else if (state == SHIFT) begin
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Registered outputs decoded from the next state so they line up with it.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      mode_q <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == LOAD) || (state_nx == SHIFT);
      done_q <= (state_nx == DONE);
      case (state_nx)
        LOAD:    mode_q <= 2'b11;
        SHIFT:   mode_q <= (op_nx == 2'b10) ? 2'b10 : 2'b01;
        default: mode_q <= 2'b00;
      endcase
    end
  end

  assign bus.S1    = mode_q[1];
  assign bus.S0    = mode_q[0];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.I_par = data_q;

  // Serial inputs are steered combinationally so the register sees live data.
  always_comb begin
    bus.MSB_in = 1'b0;
    bus.LSB_in = 1'b0;
    if (state == SHIFT) begin
      case (op_q)
        2'b01:   bus.MSB_in = bus.serial_in;
        2'b10:   bus.LSB_in = bus.serial_in;
        2'b11:   bus.MSB_in = bus.A_par[0];
        default: ;
      endcase
    end
  end

endmodule
